// File: rtl/fb_pattern_writer.sv
// Wishbone write master that fills a frame buffer with a white grid on black,
// one 32-bit word per pixel at byte address 4*(y*HDISP + x), releasing the bus every BURST words.
module fb_pattern_writer #(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int BURST = 64,
  parameter int GRID  = 16
) (
  input  logic        wshb_clk,
  input  logic        wshb_rst_n,
  input  logic        start,
  input  logic        continuous,
  output logic        busy,
  output logic        frame_done,
  output logic [31:0] wshb_adr,
  output logic [31:0] wshb_dat_ms,
  output logic        wshb_cyc,
  output logic        wshb_stb,
  output logic        wshb_we,
  output logic [3:0]  wshb_sel,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  input  logic        wshb_ack
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int BW = $clog2(BURST + 1);

  localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BURST - 1);
  localparam logic [XW-1:0] X_MASK = XW'(GRID - 1);
  localparam logic [YW-1:0] Y_MASK = YW'(GRID - 1);

  typedef enum logic [1:0] {IDLE, WRITE, YIELD, FEND} state_t;

  state_t          state;
  logic [XW-1:0]   x, x_nxt;
  logic [YW-1:0]   y, y_nxt;
  logic [BW-1:0]   bcnt;
  logic            last_px;
  logic            burst_end;

  // GRID is a power of two, so "mod GRID == 0" is a test of the low bits.
  function automatic logic [31:0] pixel(input logic [XW-1:0] px, input logic [YW-1:0] py);
    return (((px & X_MASK) == '0) || ((py & Y_MASK) == '0)) ? 32'h00FF_FFFF : 32'h0000_0000;
  endfunction

  always_comb begin
    x_nxt = x + 1'b1;
    y_nxt = y;
    if (x == X_LAST) begin
      x_nxt = '0;
      y_nxt = y + 1'b1;
    end
  end

  assign last_px   = (x == X_LAST) && (y == Y_LAST);
  assign burst_end = (bcnt == B_LAST);

  assign wshb_sel = 4'b1111;
  assign wshb_cti = 3'b000;
  assign wshb_bte = 2'b00;

  always_ff @(posedge wshb_clk or negedge wshb_rst_n) begin
    if (!wshb_rst_n) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      bcnt        <= '0;
      wshb_adr    <= '0;
      wshb_dat_ms <= '0;
      wshb_cyc    <= 1'b0;
      wshb_stb    <= 1'b0;
      wshb_we     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start || continuous) begin
            state       <= WRITE;
            x           <= '0;
            y           <= '0;
            bcnt        <= '0;
            wshb_adr    <= '0;
            wshb_dat_ms <= pixel('0, '0);
            wshb_cyc    <= 1'b1;
            wshb_stb    <= 1'b1;
            wshb_we     <= 1'b1;
            busy        <= 1'b1;
          end
        end
        WRITE: begin
          if (wshb_ack) begin
            // Frame end wins over a coinciding burst boundary.
            if (last_px) begin
              state       <= FEND;
              x           <= '0;
              y           <= '0;
              bcnt        <= '0;
              wshb_adr    <= '0;
              wshb_dat_ms <= pixel('0, '0);
              wshb_cyc    <= 1'b0;
              wshb_stb    <= 1'b0;
              wshb_we     <= 1'b0;
              frame_done  <= 1'b1;
            end else begin
              x           <= x_nxt;
              y           <= y_nxt;
              wshb_adr    <= wshb_adr + 32'd4;
              wshb_dat_ms <= pixel(x_nxt, y_nxt);
              if (burst_end) begin
                state    <= YIELD;
                bcnt     <= '0;
                wshb_cyc <= 1'b0;
                wshb_stb <= 1'b0;
                wshb_we  <= 1'b0;
              end else begin
                bcnt <= bcnt + 1'b1;
              end
            end
          end
        end
        YIELD: begin
          state    <= WRITE;
          wshb_cyc <= 1'b1;
          wshb_stb <= 1'b1;
          wshb_we  <= 1'b1;
        end
        FEND: begin
          if (continuous) begin
            state    <= WRITE;
            wshb_cyc <= 1'b1;
            wshb_stb <= 1'b1;
            wshb_we  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fb_pattern_writer.md
# fb_pattern_writer

Wishbone write master that fills a frame buffer in SDRAM with a grid test pattern, one 32-bit word per pixel. It produces the same memory layout the video display path reads: byte address 4·(y·HDISP + x), pixel in bits [23:0]. It releases the bus periodically so the display reader can arbitrate onto the shared SDRAM port. It can write a single frame on demand or rewrite frames continuously.

## Interface
Parameters:
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- BURST, 64, words written before a mandatory bus release; range 1 to 2^16
- GRID, 16, grid pitch in pixels; power of two

Ports:
- wshb_clk  in  1  bus clock; the only clock of the block
- wshb_rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request to write one frame; ignored while busy=1
- continuous  in  1  sampled at each frame end; 1 starts the next frame immediately
- busy  out  1  high from start acceptance until return to IDLE
- frame_done  out  1  one-cycle pulse after the last word of a frame is acknowledged
- wshb_adr  out  32  byte address
- wshb_dat_ms  out  32  write data, {8'h00, rgb}
- wshb_cyc  out  1  bus cycle
- wshb_stb  out  1  transfer request
- wshb_we  out  1  write enable; constant 1 whenever cyc=1
- wshb_sel  out  4  byte lanes; constant 4'b1111
- wshb_cti  out  3  constant 3'b000 (classic)
- wshb_bte  out  2  constant 2'b00
- wshb_ack  in  1  slave acknowledge

## Operation
- Internal counters:
  - x: 0..HDISP-1
  - y: 0..VDISP-1
  - bcnt: 0..BURST-1
- Address = 4·(y·HDISP + x). Use a running increment (+4 per acked word), not a multiplier. Width is 32 bits.
- Pixel value: rgb = 24'hFFFFFF if x mod GRID == 0 or y mod GRID == 0; otherwise 24'h000000. Compute it from the current x and y, as low-bit zero tests.
- FSM states and transitions:
  - IDLE: cyc=stb=0. start=1 or continuous=1 → WRITE with x=y=bcnt=0, adr=0.
  - WRITE: cyc=stb=we=1. On ack:
    - Last pixel (x=HDISP-1, y=VDISP-1) → FEND.
    - Otherwise, if bcnt=BURST-1 → YIELD, with bcnt cleared.
    - Otherwise advance x (wrapping to 0 and incrementing y at HDISP-1), adr += 4, bcnt++ and stay in WRITE.
  - YIELD: cyc=stb=0 for exactly one cycle → WRITE. The address and pixel are already advanced.
  - FEND: cyc=stb=0. frame_done=1 for this cycle. x, y, adr and bcnt are cleared. Then:
    - continuous=1 → WRITE.
    - continuous=0 → IDLE.
- busy = (state != IDLE).
- A frame-end takes priority over a burst boundary. When the last pixel coincides with bcnt=BURST-1, go to FEND, not YIELD.
- Dropping continuous mid-frame finishes the current frame, then goes to IDLE.
- start asserted in FEND or YIELD is ignored.

## Timing
- Reset, asynchronous with immediate effect on all outputs: state=IDLE, cyc=stb=we=0, adr=0, dat_ms=0, busy=0, frame_done=0. A reset mid-transfer abandons the word. On release, the block waits for start or continuous.
- All outputs are registered except the constants sel, cti and bte.
- Start latency: start sampled high at edge N → cyc=stb=1 with adr=0 after edge N.
- Handshake: adr, dat_ms and stb are held stable until the edge at which ack=1 is sampled. ack may be high in the first cycle of stb (zero wait states). With continuous ack, one word is written per clock inside a burst.
- ack sampled while stb=0 is ignored.
- With ack tied high, a frame takes HDISP·VDISP + ceil(HDISP·VDISP/BURST) − 1 + 1 cycles: words, plus YIELD cycles, plus FEND. The last yield is replaced by FEND.
- frame_done asserts in the cycle after the final ack edge.

## Test plan
Parameters for the bench unless stated: HDISP=32, VDISP=4, BURST=8, GRID=16, with a memory model that acks with 0 to 3 random wait states.
- Reset and single frame:
  - Stimulus: reset, then a start pulse, with continuous=0.
  - Required response: 128 writes to addresses 0x000..0x1FC, each written once, in order.
  - Data is 0x00FFFFFF at x∈{0,16} or y=0, and 0x00000000 elsewhere; e.g. adr 0x084 (x=1, y=1) holds 0.
  - One frame_done pulse, then busy=0.
- Yield:
  - Stimulus: ack tied to 1.
  - Required response: cyc low for exactly 1 cycle after every 8th ack, 15 yields per frame, and total frame time 144 cycles from start to frame_done.
- Handshake hold:
  - Stimulus: a 5-cycle ack stall on the word at adr 0x040.
  - Required response: adr and dat_ms are unchanged throughout the stall, and the next address is 0x044.
- Continuous and priority:
  - Stimulus: continuous=1, with BURST=128 to test the coincidence case.
  - Required response: FEND (not YIELD) after the last word.
  - adr returns to 0 one cycle after frame_done.
  - Deasserting continuous mid-frame stops after that frame's frame_done.
- Reset mid-operation:
  - Stimulus: assert wshb_rst_n=0 during a stalled write at adr 0x100.
  - Required response: cyc, stb, adr and busy go to 0 without a clock edge. After release with no start, nothing is written.
- Ignored start:
  - Stimulus: start pulses during WRITE, YIELD and FEND, with continuous=0.
  - Required response: exactly one frame is written.
